rf_ctrl_responder: RTL and testbench

Half-duplex RS-485 responder for the RF control link, sitting at the RF-module end of the serial channel. It parses fixed-length control frames delivered byte-by-byte by a UART receiver and validates their header and checksum. It latches the decoded frequency and gain settings and returns a 5-byte acknowledge frame through a UART transmitter after a programmable line turnaround, driving the transceiver direction pin.

---
 rtl/rf_ctrl_responder.sv | 189 ++++++++++++++++++
 tb/tb_rf_ctrl_responder.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_ctrl_responder.sv
// RS-485 RF control link responder: parses 8-byte control frames, latches
// frequency/gain settings and returns a 5-byte acknowledge after line turnaround.
module rf_ctrl_responder #(
  parameter int unsigned P_BYTE_TIMEOUT = 10000,
  parameter int unsigned P_TURN_CYC     = 2000,
  parameter int unsigned P_GUARD_CYC    = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  i_rx_byte,
  input  logic        i_rx_byte_vld,
  output logic [7:0]  o_tx_byte,
  output logic        o_tx_byte_vld,
  input  logic        i_tx_byte_rdy,
  input  logic        i_tx_idle,
  output logic        o_tx_ctrl,
  output logic [15:0] o_rf_freq,
  output logic [15:0] o_up_gain,
  output logic [15:0] o_down_gain,
  output logic        o_cfg_vld,
  output logic [31:0] o_frame_cnt,
  output logic [31:0] o_err_cnt
);

  typedef enum logic [2:0] {
    HUNT0, HUNT1, BODY, TURN, GUARD_ON, SEND, DRAIN, GUARD_OFF
  } state_t;

  state_t      state;
  logic [31:0] cnt;       // inter-byte timer in HUNT1/BODY, phase timer elsewhere
  logic [2:0]  idx;
  logic [7:0]  cmd;
  logic [31:0] data;
  logic [7:0]  chk;
  logic [7:0]  rsp_cmd;
  logic        rsp_bad;
  logic        cmd_ok;
  logic [7:0]  tx_next;

  always_comb begin
    cmd_ok = (cmd == 8'h01) || (cmd == 8'h02) || (cmd == 8'h03);
  end

  // Reply byte that follows the one currently at index idx.
  always_comb begin
    tx_next = 8'h55;
    case (idx)
      3'd0:    tx_next = 8'hAA;
      3'd1:    tx_next = rsp_cmd;
      3'd2:    tx_next = {7'd0, rsp_bad};
      3'd3:    tx_next = rsp_cmd ^ {7'd0, rsp_bad};
      default: tx_next = 8'h55;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= HUNT0;
      cnt           <= '0;
      idx           <= '0;
      cmd           <= '0;
      data          <= '0;
      chk           <= '0;
      rsp_cmd       <= '0;
      rsp_bad       <= 1'b0;
      o_tx_byte     <= '0;
      o_tx_byte_vld <= 1'b0;
      o_tx_ctrl     <= 1'b0;
      o_rf_freq     <= '0;
      o_up_gain     <= '0;
      o_down_gain   <= '0;
      o_cfg_vld     <= 1'b0;
      o_frame_cnt   <= '0;
      o_err_cnt     <= '0;
    end else begin
      o_cfg_vld <= 1'b0;
      case (state)
        HUNT0: begin
          if (i_rx_byte_vld && i_rx_byte == 8'hAA) begin
            state <= HUNT1;
            cnt   <= '0;
          end
        end
        HUNT1: begin
          if (i_rx_byte_vld) begin
            cnt <= '0;
            if (i_rx_byte == 8'h55) begin
              state <= BODY;
              idx   <= '0;
            end else if (i_rx_byte != 8'hAA) begin
              state <= HUNT0;
            end
          end else if (cnt == P_BYTE_TIMEOUT - 1) begin
            o_err_cnt <= o_err_cnt + 32'd1;
            state     <= HUNT0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        BODY: begin
          if (i_rx_byte_vld) begin
            cnt <= '0;
            if (idx == 3'd0) begin
              cmd <= i_rx_byte;
              chk <= i_rx_byte;
              idx <= idx + 3'd1;
            end else if (idx != 3'd5) begin
              data <= {data[23:0], i_rx_byte};
              chk  <= chk ^ i_rx_byte;
              idx  <= idx + 3'd1;
            end else if (i_rx_byte == chk) begin
              o_frame_cnt <= o_frame_cnt + 32'd1;
              rsp_cmd     <= cmd | 8'h80;
              rsp_bad     <= !cmd_ok;
              state       <= TURN;
              case (cmd)
                8'h01: begin
                  o_rf_freq <= data[15:0];
                  o_cfg_vld <= 1'b1;
                end
                8'h02: begin
                  o_up_gain   <= data[31:16];
                  o_down_gain <= data[15:0];
                  o_cfg_vld   <= 1'b1;
                end
                default: ;
              endcase
            end else begin
              o_err_cnt <= o_err_cnt + 32'd1;
              state     <= HUNT0;
            end
          end else if (cnt == P_BYTE_TIMEOUT - 1) begin
            o_err_cnt <= o_err_cnt + 32'd1;
            state     <= HUNT0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        TURN: begin
          // Counts one extra cycle so the driver enable lands P_TURN_CYC+1 after CHK.
          if (cnt == P_TURN_CYC) begin
            o_tx_ctrl <= 1'b1;
            cnt       <= '0;
            state     <= GUARD_ON;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        GUARD_ON: begin
          if (cnt == P_GUARD_CYC - 1) begin
            o_tx_byte     <= 8'h55;
            o_tx_byte_vld <= 1'b1;
            idx           <= '0;
            state         <= SEND;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        SEND: begin
          if (i_tx_byte_rdy) begin
            if (idx == 3'd4) begin
              o_tx_byte_vld <= 1'b0;
              state         <= DRAIN;
            end else begin
              o_tx_byte <= tx_next;
              idx       <= idx + 3'd1;
            end
          end
        end
        DRAIN: begin
          if (i_tx_idle) begin
            cnt   <= '0;
            state <= GUARD_OFF;
          end
        end
        GUARD_OFF: begin
          if (cnt == P_GUARD_CYC - 1) begin
            o_tx_ctrl <= 1'b0;
            state     <= HUNT0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: state <= HUNT0;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_ctrl_responder.sv
// Directed bench for rf_ctrl_responder: scoreboard of expected reply bytes,
// timing checks on driver enable and byte timing, settings and counters.
module tb_rf_ctrl_responder;

  localparam int unsigned TO    = 40;
  localparam int unsigned TURN  = 12;
  localparam int unsigned GUARD = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  i_rx_byte;
  logic        i_rx_byte_vld;
  logic [7:0]  o_tx_byte;
  logic        o_tx_byte_vld;
  logic        i_tx_byte_rdy;
  logic        i_tx_idle;
  logic        o_tx_ctrl;
  logic [15:0] o_rf_freq;
  logic [15:0] o_up_gain;
  logic [15:0] o_down_gain;
  logic        o_cfg_vld;
  logic [31:0] o_frame_cnt;
  logic [31:0] o_err_cnt;

  rf_ctrl_responder #(
    .P_BYTE_TIMEOUT(TO),
    .P_TURN_CYC    (TURN),
    .P_GUARD_CYC   (GUARD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_rx_byte    (i_rx_byte),
    .i_rx_byte_vld(i_rx_byte_vld),
    .o_tx_byte    (o_tx_byte),
    .o_tx_byte_vld(o_tx_byte_vld),
    .i_tx_byte_rdy(i_tx_byte_rdy),
    .i_tx_idle    (i_tx_idle),
    .o_tx_ctrl    (o_tx_ctrl),
    .o_rf_freq    (o_rf_freq),
    .o_up_gain    (o_up_gain),
    .o_down_gain  (o_down_gain),
    .o_cfg_vld    (o_cfg_vld),
    .o_frame_cnt  (o_frame_cnt),
    .o_err_cnt    (o_err_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int busy = 0;
  int last_hs = 0;
  logic [7:0] expq[$];
  logic [7:0] prev_byte = '0;
  logic       prev_hold = 1'b0;

  // UART TX model: shift register busy for 4 cycles after each accepted byte.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) busy <= 0;
    else if (o_tx_byte_vld && i_tx_byte_rdy) busy <= 4;
    else if (busy != 0) busy <= busy - 1;
  end
  assign i_tx_idle = (busy == 0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard consumer: each vld&rdy handshake pops one expected reply byte.
  always @(negedge clk) begin
    if (rst) begin
      prev_hold <= 1'b0;
    end else begin
      if (prev_hold && o_tx_byte_vld) chk("tx_hold_stable", o_tx_byte, prev_byte);
      if (o_tx_byte_vld && i_tx_byte_rdy) begin
        last_hs <= cyc + 1;
        tests++;
        assert (expq.size() != 0) else begin
          fails++;
          $error("FAIL tx_unexpected: observed byte %02h expected none", o_tx_byte);
        end
        if (expq.size() != 0) chk("tx_byte", o_tx_byte, expq.pop_front());
      end
      prev_hold <= o_tx_byte_vld && !i_tx_byte_rdy;
      prev_byte <= o_tx_byte;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_byte     = b;
    i_rx_byte_vld = 1'b1;
    step();
    i_rx_byte_vld = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] b[$]);
    foreach (b[i]) send_byte(b[i]);
  endtask

  task automatic push_reply(input logic [7:0] cmd, input logic [7:0] status);
    expq.push_back(8'h55);
    expq.push_back(8'hAA);
    expq.push_back(cmd | 8'h80);
    expq.push_back(status);
    expq.push_back((cmd | 8'h80) ^ status);
  endtask

  task automatic wait_rise();
    int n = 0;
    while (!o_tx_ctrl && n < 200) begin step(); n++; end
    chk("tx_ctrl_rise_seen", o_tx_ctrl, 1);
  endtask

  task automatic wait_vld();
    int n = 0;
    while (!o_tx_byte_vld && n < 200) begin step(); n++; end
    chk("tx_vld_seen", o_tx_byte_vld, 1);
  endtask

  task automatic wait_fall();
    int n = 0;
    while (o_tx_ctrl && n < 2000) begin step(); n++; end
    chk("tx_ctrl_fall_seen", o_tx_ctrl, 0);
    chk("guard_off_cycles", cyc, last_hs + 5 + GUARD);
    chk("reply_complete", expq.size(), 0);
  endtask

  // Called right after the CHK strobe edge.
  task automatic timed_reply();
    int n = 0;
    while (!o_tx_ctrl && n < TURN + 20) begin
      step();
      n++;
      if (n == 1) chk("cfg_vld_width", o_cfg_vld, 0);
    end
    chk("turn_cycles", n, TURN + 1);
    n = 0;
    while (!o_tx_byte_vld && n < GUARD + 20) begin step(); n++; end
    chk("guard_on_cycles", n, GUARD);
    chk("first_byte", o_tx_byte, 8'h55);
    wait_fall();
  endtask

  initial begin
    logic [7:0] fr[$];
    rst = 1'b1;
    i_rx_byte = '0;
    i_rx_byte_vld = 1'b0;
    i_tx_byte_rdy = 1'b1;
    repeat (3) step();
    chk("rst_tx_ctrl", o_tx_ctrl, 0);
    chk("rst_tx_vld", o_tx_byte_vld, 0);
    chk("rst_tx_byte", o_tx_byte, 0);
    chk("rst_freq", o_rf_freq, 0);
    chk("rst_up", o_up_gain, 0);
    chk("rst_down", o_down_gain, 0);
    chk("rst_cfg_vld", o_cfg_vld, 0);
    chk("rst_frame_cnt", o_frame_cnt, 0);
    chk("rst_err_cnt", o_err_cnt, 0);
    rst = 1'b0;
    step();

    // Set frequency
    push_reply(8'h01, 8'h00);
    fr = '{8'hAA, 8'h55, 8'h01, 8'h00, 8'h00, 8'h0F, 8'hA0, 8'hAE};
    send_bytes(fr);
    chk("freq_cfg_vld", o_cfg_vld, 1);
    chk("freq_value", o_rf_freq, 16'h0FA0);
    chk("freq_frame_cnt", o_frame_cnt, 1);
    timed_reply();

    // Set gain
    push_reply(8'h02, 8'h00);
    fr = '{8'hAA, 8'h55, 8'h02, 8'h00, 8'h12, 8'h00, 8'h34, 8'h24};
    send_bytes(fr);
    chk("gain_cfg_vld", o_cfg_vld, 1);
    chk("gain_up", o_up_gain, 16'h0012);
    chk("gain_down", o_down_gain, 16'h0034);
    timed_reply();

    // Bad checksum: no reply, error counted, settings kept
    fr = '{8'hAA, 8'h55, 8'h01, 8'h00, 8'h00, 8'h0F, 8'hA0, 8'h00};
    send_bytes(fr);
    chk("badchk_err_cnt", o_err_cnt, 1);
    chk("badchk_cfg_vld", o_cfg_vld, 0);
    repeat (TURN + GUARD + 5) step();
    chk("badchk_no_tx", o_tx_ctrl, 0);
    chk("badchk_freq", o_rf_freq, 16'h0FA0);
    chk("badchk_frame_cnt", o_frame_cnt, 2);

    // Resync on repeated AA, query command
    push_reply(8'h03, 8'h00);
    fr = '{8'hAA, 8'hAA, 8'h55, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03};
    send_bytes(fr);
    chk("query_cfg_vld", o_cfg_vld, 0);
    chk("query_frame_cnt", o_frame_cnt, 3);
    timed_reply();

    // Inter-byte timeout
    fr = '{8'hAA, 8'h55, 8'h01};
    send_bytes(fr);
    repeat (TO - 1) step();
    chk("timeout_early", o_err_cnt, 1);
    step();
    chk("timeout_err_cnt", o_err_cnt, 2);

    // Byte arriving on the timeout cycle wins
    send_byte(8'hAA);
    repeat (TO - 1) step();
    push_reply(8'h01, 8'h00);
    fr = '{8'h55, 8'h01, 8'h00, 8'h00, 8'h0F, 8'hA0, 8'hAE};
    send_bytes(fr);
    chk("race_err_cnt", o_err_cnt, 2);
    chk("race_frame_cnt", o_frame_cnt, 4);
    timed_reply();

    // Bad command, with a valid frame injected during turnaround
    push_reply(8'h07, 8'h01);
    fr = '{8'hAA, 8'h55, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h07};
    send_bytes(fr);
    chk("badcmd_frame_cnt", o_frame_cnt, 5);
    chk("badcmd_cfg_vld", o_cfg_vld, 0);
    fr = '{8'hAA, 8'h55, 8'h01, 8'h00, 8'h00, 8'h12, 8'h34, 8'h27};
    send_bytes(fr);
    wait_rise();
    wait_fall();
    chk("inject_frame_cnt", o_frame_cnt, 5);
    chk("inject_freq", o_rf_freq, 16'h0FA0);
    chk("inject_err_cnt", o_err_cnt, 2);

    // TX backpressure mid-reply
    push_reply(8'h01, 8'h00);
    fr = '{8'hAA, 8'h55, 8'h01, 8'h00, 8'h00, 8'h0F, 8'hA0, 8'hAE};
    send_bytes(fr);
    wait_vld();
    step();
    step();
    i_tx_byte_rdy = 1'b0;
    repeat (50) step();
    chk("bp_vld_held", o_tx_byte_vld, 1);
    chk("bp_byte_held", o_tx_byte, 8'h81);
    i_tx_byte_rdy = 1'b1;
    wait_fall();

    // Asynchronous reset mid-SEND
    push_reply(8'h02, 8'h00);
    fr = '{8'hAA, 8'h55, 8'h02, 8'h00, 8'h12, 8'h00, 8'h34, 8'h24};
    send_bytes(fr);
    wait_vld();
    step();
    #1;
    rst = 1'b1;
    #1;
    chk("arst_tx_ctrl", o_tx_ctrl, 0);
    chk("arst_tx_vld", o_tx_byte_vld, 0);
    chk("arst_tx_byte", o_tx_byte, 0);
    chk("arst_freq", o_rf_freq, 0);
    chk("arst_up", o_up_gain, 0);
    chk("arst_down", o_down_gain, 0);
    chk("arst_frame_cnt", o_frame_cnt, 0);
    chk("arst_err_cnt", o_err_cnt, 0);
    expq.delete();
    #2;
    rst = 1'b0;
    step();

    push_reply(8'h01, 8'h00);
    fr = '{8'hAA, 8'h55, 8'h01, 8'h00, 8'h00, 8'h0F, 8'hA0, 8'hAE};
    send_bytes(fr);
    chk("post_rst_frame_cnt", o_frame_cnt, 1);
    chk("post_rst_freq", o_rf_freq, 16'h0FA0);
    timed_reply();

    repeat (5) step();
    chk("final_queue_empty", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no completion expected $finish");
    $fatal(1);
  end

endmodule
